// File: rtl/instruction_sequencer_pkg.sv
// Shared encodings for the multi-cycle instruction sequencer: FSM states, datapath mux
// selects and the decoder's one-hot opcode class bit positions.
package instruction_sequencer_pkg;

    localparam int NUM_CLASSES = 11;

    localparam int ONEHOT_LUI_INDEX       = 0;
    localparam int ONEHOT_AUIPC_INDEX     = 1;
    localparam int ONEHOT_JAL_INDEX       = 2;
    localparam int ONEHOT_JALR_INDEX      = 3;
    localparam int ONEHOT_BRANCH_INDEX    = 4;
    localparam int ONEHOT_LOAD_INDEX      = 5;
    localparam int ONEHOT_STORE_INDEX     = 6;
    localparam int ONEHOT_ITYPE_ALU_INDEX = 7;
    localparam int ONEHOT_RTYPE_ALU_INDEX = 8;
    localparam int ONEHOT_FENCE_INDEX     = 9;
    localparam int ONEHOT_DEBUG_INDEX     = 10;

    typedef enum logic [2:0] {
        ST_FETCH      = 3'd0,
        ST_DECODE     = 3'd1,
        ST_EXECUTE    = 3'd2,
        ST_MEM        = 3'd3,
        ST_WRITEBACK  = 3'd4,
        ST_TRAP       = 3'd5,
        ST_DEBUG_HALT = 3'd6
    } state_e;

    localparam logic [1:0] ALU_A_RS1    = 2'd0;
    localparam logic [1:0] ALU_A_PC     = 2'd1;
    localparam logic [1:0] ALU_A_ZERO   = 2'd2;
    localparam logic       ALU_B_RS2    = 1'b0;
    localparam logic       ALU_B_IMM    = 1'b1;
    localparam logic       PC_SRC_PLUS4 = 1'b0;
    localparam logic       PC_SRC_ALU   = 1'b1;
    localparam logic [1:0] RD_SRC_ALU   = 2'd0;
    localparam logic [1:0] RD_SRC_MEM   = 2'd1;
    localparam logic [1:0] RD_SRC_PC4   = 2'd2;

    function automatic logic is_onehot(input logic [NUM_CLASSES-1:0] v);
        return (v != '0) && ((v & (v - NUM_CLASSES'(1))) == '0);
    endfunction

endpackage

// File: rtl/instruction_sequencer_wait_timer.sv
// Wait counter for memory handshakes: counts stalled cycles and flags the cycle whose
// stall makes the count reach MAX_WAIT_CYCLES (0 disables the flag entirely).
module sequencer_wait_timer #(
    parameter int MAX_WAIT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (MAX_WAIT_CYCLES < 2) ? 1 : $clog2(MAX_WAIT_CYCLES + 1);

    generate
        if (MAX_WAIT_CYCLES == 0) begin : g_disabled
            assign expired_o = 1'b0;
        end else begin : g_enabled
            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;

            always_comb begin
                count_d = count_q;
                if (clear_i) begin
                    count_d = '0;
                end else if (enable_i && (count_q != CW'(MAX_WAIT_CYCLES))) begin
                    count_d = count_q + CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign expired_o = enable_i && (count_q == CW'(MAX_WAIT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback control FSM with retire counter and sticky trap.
// Define INSTRUCTION_SEQUENCER_DEBUG_HALT_EN to make DEBUG instructions halt until debug_resume.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int INSTRET_WIDTH   = 32,
    parameter int MAX_WAIT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    input  logic                     imem_ready,
    output logic                     ir_load,
    input  logic [NUM_CLASSES-1:0]   opcode_selection,
    input  logic                     decoding_error,
    input  logic                     branch_taken,
    output logic                     dmem_req,
    output logic                     dmem_we,
    input  logic                     dmem_ready,
    output logic [1:0]               alu_a_sel,
    output logic                     alu_b_sel,
    output logic                     pc_write,
    output logic                     pc_src,
    output logic                     rd_write,
    output logic [1:0]               rd_src,
    output logic                     trap,
    output logic                     halted,
`ifdef INSTRUCTION_SEQUENCER_DEBUG_HALT_EN
    input  logic                     debug_resume,
`endif
    output logic [INSTRET_WIDTH-1:0] instret
);

    state_e                   state_q, state_d;
    logic [NUM_CLASSES-1:0]   class_q, class_d;
    logic                     taken_q, taken_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
    logic                     timer_clear, timer_enable, timer_expired;

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
    logic is_itype, is_rtype, is_fence, is_debug;

    assign is_lui    = class_q[ONEHOT_LUI_INDEX];
    assign is_auipc  = class_q[ONEHOT_AUIPC_INDEX];
    assign is_jal    = class_q[ONEHOT_JAL_INDEX];
    assign is_jalr   = class_q[ONEHOT_JALR_INDEX];
    assign is_branch = class_q[ONEHOT_BRANCH_INDEX];
    assign is_load   = class_q[ONEHOT_LOAD_INDEX];
    assign is_store  = class_q[ONEHOT_STORE_INDEX];
    assign is_itype  = class_q[ONEHOT_ITYPE_ALU_INDEX];
    assign is_rtype  = class_q[ONEHOT_RTYPE_ALU_INDEX];
    assign is_fence  = class_q[ONEHOT_FENCE_INDEX];
    assign is_debug  = class_q[ONEHOT_DEBUG_INDEX];

    // Kept outside the FSM block so the timer's expired flag never feeds back into its own enable.
    assign timer_enable = !reset && (((state_q == ST_FETCH) && !imem_ready) ||
                                     ((state_q == ST_MEM) && !dmem_ready));
    assign timer_clear  = (state_d != state_q);

    sequencer_wait_timer #(
        .MAX_WAIT_CYCLES(MAX_WAIT_CYCLES)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (timer_clear),
        .enable_i  (timer_enable),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        taken_d   = taken_q;
        instret_d = instret_q;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_a_sel = ALU_A_RS1;
        alu_b_sel = ALU_B_RS2;
        pc_write  = 1'b0;
        pc_src    = PC_SRC_PLUS4;
        rd_write  = 1'b0;
        rd_src    = RD_SRC_ALU;
        trap      = 1'b0;
        halted    = 1'b0;

        // Operand muxes follow the latched class from EXECUTE until the instruction retires.
        if ((state_q == ST_EXECUTE) || (state_q == ST_MEM) || (state_q == ST_WRITEBACK)) begin
            if (is_lui || is_fence || is_debug) begin
                alu_a_sel = ALU_A_ZERO;
            end else if (is_auipc || is_jal || is_branch) begin
                alu_a_sel = ALU_A_PC;
            end
            alu_b_sel = is_rtype ? ALU_B_RS2 : ALU_B_IMM;
        end

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end else if (timer_expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (decoding_error || !is_onehot(opcode_selection)) begin
                    state_d = ST_TRAP;
                end else begin
                    class_d = opcode_selection;
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                taken_d = branch_taken;
                if (is_load || is_store) begin
                    state_d = ST_MEM;
`ifdef INSTRUCTION_SEQUENCER_DEBUG_HALT_EN
                end else if (is_debug) begin
                    state_d = ST_DEBUG_HALT;
`endif
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ready) begin
                    state_d = ST_WRITEBACK;
                end else if (timer_expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WRITEBACK: begin
                pc_write  = 1'b1;
                pc_src    = (is_jal || is_jalr || (is_branch && taken_q)) ? PC_SRC_ALU : PC_SRC_PLUS4;
                rd_write  = is_lui || is_auipc || is_jal || is_jalr || is_load || is_itype || is_rtype;
                rd_src    = (is_jal || is_jalr) ? RD_SRC_PC4 : (is_load ? RD_SRC_MEM : RD_SRC_ALU);
                instret_d = instret_q + INSTRET_WIDTH'(1);
                state_d   = ST_FETCH;
            end
            ST_TRAP: begin
                trap   = 1'b1;
                halted = 1'b1;
            end
`ifdef INSTRUCTION_SEQUENCER_DEBUG_HALT_EN
            ST_DEBUG_HALT: begin
                halted = 1'b1;
                if (debug_resume) begin
                    state_d = ST_WRITEBACK;
                end
            end
`endif
            default: begin
                state_d = ST_TRAP;
            end
        endcase

        // The state register only clears at the edge, so outputs are forced quiet during reset.
        if (reset) begin
            imem_req  = 1'b0;
            ir_load   = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            alu_a_sel = ALU_A_RS1;
            alu_b_sel = ALU_B_RS2;
            pc_write  = 1'b0;
            pc_src    = PC_SRC_PLUS4;
            rd_write  = 1'b0;
            rd_src    = RD_SRC_ALU;
            trap      = 1'b0;
            halted    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            class_q   <= '0;
            taken_q   <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            taken_q   <= taken_d;
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Multi-cycle control FSM for the core.
- Sequences fetch → decode → execute → memory → writeback around the instruction decoder's one-hot opcode_selection and decoding_error outputs.
- Drives the IR load, memory handshakes, ALU operand muxes, PC update and register-file write strobes.
- Counts retired instructions and raises a sticky trap on illegal or timed-out instructions.

Parameters:
INSTRET_WIDTH, 32, width of the retired-instruction counter.
MAX_WAIT_CYCLES, 16, cycles a memory request may wait for ready before trapping; 0 disables the timeout.

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
imem_req  out  1  instruction fetch request, held until imem_ready
imem_ready  in  1  fetch data valid this cycle
ir_load  out  1  capture fetched word into instruction register
opcode_selection  in  11  one-hot class from decoder (ONEHOT_*_INDEX bit positions)
decoding_error  in  1  decoder error flag
branch_taken  in  1  comparator result, sampled in EXECUTE
dmem_req  out  1  data memory request, held until dmem_ready
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
dmem_ready  in  1  data access complete this cycle
alu_a_sel  out  2  0 = rs1, 1 = pc, 2 = zero
alu_b_sel  out  1  0 = rs2, 1 = immediate
pc_write  out  1  one-cycle PC update strobe
pc_src  out  1  0 = pc+4, 1 = ALU result (jump/branch target)
rd_write  out  1  one-cycle register-file write strobe
rd_src  out  2  0 = ALU, 1 = memory data, 2 = pc+4
trap  out  1  sticky illegal-instruction / timeout flag
halted  out  1  core stopped (TRAP or debug halt)
instret  out  INSTRET_WIDTH  retired instruction count

Behaviour:
- Reset
  - State = FETCH; instret = 0; trap = 0; wait counter = 0.
  - All strobes and requests deassert in the reset cycle.
  - Reset mid-operation abandons any outstanding request with no retire.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- FETCH
  - imem_req = 1.
  - On imem_ready: ir_load = 1 in the same cycle → DECODE.
  - If MAX_WAIT_CYCLES ≠ 0 and the wait counter reaches MAX_WAIT_CYCLES without ready: → TRAP.
- DECODE (1 cycle)
  - → TRAP if decoding_error = 1, or if opcode_selection is zero or not one-hot.
  - Otherwise latch the class register → EXECUTE.
- EXECUTE (1 cycle)
  - Drive ALU muxes per class. Muxes stay held through MEM and WRITEBACK.
  - Sample branch_taken into a register.
  - LOAD/STORE → MEM; all other classes → WRITEBACK.
- MEM
  - dmem_req = 1; dmem_we = STORE.
  - On dmem_ready → WRITEBACK.
  - Timeout handling is identical to FETCH.
- WRITEBACK (1 cycle)
  - pc_write = 1; rd_write per class; instret += 1 (wraps modulo 2^INSTRET_WIDTH) → FETCH.
- TRAP: trap = halted = 1; all requests and strobes are 0; exit only by reset.
- Class table (alu_a, alu_b, pc_src, rd_write/rd_src):
  - LUI: zero, imm, 0, 1/ALU
  - AUIPC: pc, imm, 0, 1/ALU
  - JAL: pc, imm, 1, 1/pc+4
  - JALR: rs1, imm, 1, 1/pc+4
  - BRANCH: pc, imm, taken ? 1 : 0, 0
  - LOAD: rs1, imm, 0, 1/mem
  - STORE: rs1, imm, 0, 0
  - ITYPE_ALU: rs1, imm, 0, 1/ALU
  - RTYPE_ALU: rs1, rs2, 0, 1/ALU
  - FENCE: don't care, don't care, 0, 0 (no-op)
  - DEBUG: see Optional Feature
- Latency with zero-wait memory: 4 cycles per non-memory instruction, 5 per load/store.
- Ready asserted while not requesting is ignored.
- The wait counter clears on every state entry.

Optional Feature:
- Macro: INSTRUCTION_SEQUENCER_DEBUG_HALT_EN.
- Defined:
  - Adds input debug_resume (1 bit).
  - A DEBUG instruction in EXECUTE → DEBUG_HALT; halted = 1; no strobes.
  - debug_resume = 1 → WRITEBACK, which retires the instruction (pc+4, no rd write).
  - debug_resume asserted in any other state is ignored.
- Undefined: DEBUG behaves as FENCE (no-op, retires); no debug_resume port.

Decomposition:
- Shared define header holds:
  - state encodings (3-bit);
  - alu_a_sel, pc_src and rd_src encodings;
  - the existing ONEHOT_*_INDEX constants, reused unchanged.
- Sub-module: sequencer_wait_timer, the wait counter with clear/enable/expired and the MAX_WAIT_CYCLES parameter.

Test Plan:
- Reset, then ITYPE_ALU with imem_ready on the first FETCH cycle → ir_load at cycle 1; pc_write and rd_write (rd_src = 0) at cycle 4; instret = 1.
- LOAD with dmem_ready after 3 wait cycles → dmem_req held for 4 cycles with dmem_we = 0; rd_src = 1 in WRITEBACK; total latency 8 cycles.
- BRANCH with branch_taken = 1, then with branch_taken = 0 → pc_src = 1 then 0; rd_write = 0 both times; instret increments by 2.
- opcode_selection = 0, opcode_selection = 11'b00000000011, and decoding_error = 1 (three separate runs) → TRAP after DECODE; trap and halted stay 1 until reset; instret unchanged.
- imem_ready held low with MAX_WAIT_CYCLES = 16 → imem_req drops and trap rises once the wait counter reaches 16; reset asserted in MEM with a STORE pending → dmem_req = 0 the next cycle, instret = 0.
- JAL with the macro undefined, then DEBUG → rd_src = 2 and pc_src = 1 for JAL; DEBUG retires as a no-op. With the macro defined, DEBUG holds halted = 1 until a debug_resume pulse, then retires one cycle later.
